// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset vector and the fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h8000;

  typedef enum logic [1:0] {
    ST_OPC  = 2'd0,
    ST_OP1  = 2'd1,
    ST_OP2  = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/opcode_len_dec.sv
// Opcode length decoder: bits [5:4] of the opcode select a 1-, 2- or 3-byte instruction.
module opcode_len_dec
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] opcode,
  output logic [1:0]        len
);

  logic unused_opcode_bits_s;
  assign unused_opcode_bits_s = ^{opcode[7:6], opcode[3:0]};

  // Length class lookup
  always_comb begin
    len = 2'd1;
    case (opcode[5:4])
      2'b00:   len = 2'd1;
      2'b01:   len = 2'd2;
      default: len = 2'd3;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 1..3 byte instructions over the 8-bit bus and hands them
// to decode over a valid/ready handshake, honouring bus grant and execute redirects.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  output logic              cs,
  output logic              oe,
  output logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              bus_gnt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [15:0]       instr_operand,
  output logic [1:0]        instr_len,
  output logic [15:0]       instr_pc
);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [7:0]        opcode_r;
  logic [15:0]       operand_r;
  logic [1:0]        len_r;
  logic [15:0]       ipc_r;
  logic [1:0]        dec_len_s;
  logic              consume_s;

  opcode_len_dec u_len_dec (
    .opcode (data_in),
    .len    (dec_len_s)
  );

  // A byte is taken only when the bus is ours and no redirect is flushing this cycle
  assign consume_s = !rst && bus_gnt && !redirect_valid && (state_r != ST_HOLD);

  assign addr          = pc_r;
  assign cs            = consume_s;
  assign oe            = consume_s;
  assign we            = 1'b0;
  assign instr_valid   = (state_r == ST_HOLD);
  assign instr_opcode  = opcode_r;
  assign instr_operand = operand_r;
  assign instr_len     = len_r;
  assign instr_pc      = ipc_r;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = ST_OPC;
    end else if (consume_s) begin
      case (state_r)
        ST_OPC:  state_nxt_s = (dec_len_s == 2'd1) ? ST_HOLD : ST_OP1;
        ST_OP1:  state_nxt_s = (len_r == 2'd2) ? ST_HOLD : ST_OP2;
        ST_OP2:  state_nxt_s = ST_HOLD;
        default: state_nxt_s = ST_OPC;
      endcase
    end else if ((state_r == ST_HOLD) && instr_ready) begin
      state_nxt_s = ST_OPC;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, PC and instruction assembly registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_OPC;
      pc_r      <= RESET_VECTOR;
      opcode_r  <= 8'h00;
      operand_r <= 16'h0000;
      len_r     <= 2'd0;
      ipc_r     <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (consume_s) begin
        pc_r <= pc_r + 16'd1;
      end
      if (consume_s) begin
        case (state_r)
          ST_OPC: begin
            opcode_r  <= data_in;
            ipc_r     <= pc_r;
            operand_r <= 16'h0000;
            len_r     <= dec_len_s;
          end
          ST_OP1:  operand_r[7:0]  <= data_in;
          ST_OP2:  operand_r[15:8] <= data_in;
          default: operand_r       <= operand_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM model, directed timing checks and a randomized phase
// with expected instructions computed by walking the ROM image.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        cs, oe, we;
  logic [7:0]  data_in;
  logic        bus_gnt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opd;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mem [0:65535];
  int         vectors = 0;
  int         miscompares = 0;
  int         accepted = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .cs             (cs),
    .oe             (oe),
    .we             (we),
    .data_in        (data_in),
    .bus_gnt        (bus_gnt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM answers combinationally while selected
  always_comb data_in = (cs && oe) ? mem[addr] : 8'h00;

  // Expected instruction stream obtained by walking the ROM image from a start address
  function automatic void push_walk(input logic [15:0] start, input int n);
    logic [15:0] p;
    exp_t e;
    int l;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.op  = mem[p];
      l     = (e.op[5:4] == 2'd0) ? 1 : ((e.op[5:4] == 2'd1) ? 2 : 3);
      e.len = 2'(l);
      e.pc  = p;
      e.opd = 16'h0000;
      if (l >= 2) e.opd[7:0]  = mem[16'(p + 16'd1)];
      if (l == 3) e.opd[15:8] = mem[16'(p + 16'd2)];
      sb_q.push_back(e);
      p = 16'(p + 16'(l));
    end
  endfunction

  // Monitor: every handshake that will complete at the next edge is checked in order
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got instr at pc %h, required none", instr_pc);
      end else begin
        mon_e = sb_q.pop_front();
        accepted++;
        if (instr_opcode !== mon_e.op || instr_operand !== mon_e.opd ||
            instr_len !== mon_e.len || instr_pc !== mon_e.pc) begin
          miscompares++;
          $display("FAIL sb_instr: got op %h opd %h len %0d pc %h, required op %h opd %h len %0d pc %h",
                   instr_opcode, instr_operand, instr_len, instr_pc,
                   mon_e.op, mon_e.opd, mon_e.len, mon_e.pc);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_fetch(input logic [15:0] a, input int budget);
    int n;
    n = 0;
    while (!(cs && addr == a) && n < budget) begin
      adv();
      smp();
      n++;
    end
    vectors++;
    if (!(cs && addr == a)) begin
      miscompares++;
      $display("FAIL wait_fetch: addr %h not fetched within %0d cycles", a, budget);
    end
  endtask

  initial begin
    rst = 1'b1; bus_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'h02; mem[16'h8001] = 8'h07; mem[16'h8002] = 8'h04; mem[16'h8003] = 8'h00;
    mem[16'h8004] = 8'h11; mem[16'h8005] = 8'h34; mem[16'h8006] = 8'h12; mem[16'h8007] = 8'h55;
    mem[16'h8008] = 8'h30; mem[16'h8009] = 8'h80; mem[16'h800A] = 8'h07;
    mem[16'h800B] = 8'h20; mem[16'h800C] = 8'hAA; mem[16'h800D] = 8'hBB;
    mem[16'h8010] = 8'h01; mem[16'h8011] = 8'h1A; mem[16'h8012] = 8'h77;
    mem[16'hFFFF] = 8'h05; mem[16'h0000] = 8'h0C;
    for (int i = 16'h9000; i < 16'hA000; i++) mem[i] = 8'($urandom);

    smp();
    smp();
    chk("rst_cs", 32'(cs), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_addr", 32'(addr), 32'h8000);
    chk("rst_fields", {instr_opcode, instr_len, 6'h0, instr_pc}, 32'h0);
    chk("rst_operand", 32'(instr_operand), 32'h0);
    push_walk(16'h8000, 7);

    adv(); rst = 1'b0; smp();
    chk("first_addr", 32'(addr), 32'h8000);
    chk("first_cs_oe", {30'h0, cs, oe}, 32'h3);
    chk("first_valid", 32'(instr_valid), 32'h0);
    adv(); smp();
    chk("i0_valid", 32'(instr_valid), 32'h1);
    chk("i0_fields", {instr_opcode, 6'h0, instr_len, instr_pc}, 32'h02018000);
    chk("i0_cs", 32'(cs), 32'h0);
    adv(); instr_ready = 1'b0; smp();
    chk("i1_fetch", {15'h0, cs, addr}, 32'h00018001);
    for (int i = 0; i < 5; i++) begin
      adv(); smp();
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_fields", {instr_opcode, 6'h0, instr_len, instr_pc}, 32'h07018001);
      chk("stall_bus", {15'h0, cs, addr}, 32'h00008002);
    end
    adv(); instr_ready = 1'b1; smp();
    adv(); smp();
    chk("post_stall_fetch", {14'h0, instr_valid, cs, addr}, 32'h00018002);

    wait_fetch(16'h8008, 40);
    adv(); smp();
    chk("op1_addr", {15'h0, cs, addr}, 32'h00018009);
    for (int i = 0; i < 3; i++) begin
      adv(); bus_gnt = 1'b0; smp();
      chk("nognt_bus", {14'h0, instr_valid, cs, addr}, 32'h0000800A);
    end
    adv(); bus_gnt = 1'b1; smp();
    chk("op2_addr", {15'h0, cs, addr}, 32'h0001800A);
    adv(); smp();
    chk("i3b_valid", 32'(instr_valid), 32'h1);
    chk("i3b_operand", 32'(instr_operand), 32'h0780);
    chk("i3b_len", 32'(instr_len), 32'h3);
    adv(); smp();
    chk("opc_800b", {14'h0, instr_valid, cs, addr}, 32'h0001800B);

    adv();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 16'h8010;
    sb_q.delete(); push_walk(16'h8010, 2);
    smp();
    chk("redir_bus", {14'h0, instr_valid, cs, addr}, 32'h0000800C);
    adv(); redirect_valid = 1'b0; smp();
    chk("redir_target", {14'h0, instr_valid, cs, addr}, 32'h00018010);
    adv(); smp();
    chk("redir_instr", {instr_opcode, 7'h0, instr_valid, instr_pc}, 32'h01018010);

    adv(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    sb_q.delete(); push_walk(16'hFFFF, 2);
    smp();
    chk("redir2_cs", 32'(cs), 32'h0);
    adv(); redirect_valid = 1'b0; instr_ready = 1'b1; smp();
    chk("ffff_fetch", {15'h0, cs, addr}, 32'h0001FFFF);
    adv(); smp();
    chk("ffff_instr", {instr_opcode, 7'h0, instr_valid, instr_pc}, 32'h0501FFFF);
    adv(); instr_ready = 1'b0; smp();
    chk("wrap_fetch", {14'h0, instr_valid, cs, addr}, 32'h00010000);
    adv(); smp();
    chk("wrap_instr", {instr_opcode, 7'h0, instr_valid, instr_pc}, 32'h0C010000);
    adv(); rst = 1'b1; smp();
    chk("rst_hold_cs", 32'(cs), 32'h0);
    adv(); rst = 1'b0; instr_ready = 1'b1;
    sb_q.delete(); push_walk(16'h8000, 3);
    smp();
    chk("rst_hold_after", {14'h0, instr_valid, cs, addr}, 32'h00018000);

    adv(); redirect_valid = 1'b1; redirect_pc = 16'h9000;
    sb_q.delete(); push_walk(16'h9000, 300);
    smp();
    accepted = 0;
    for (int c = 0; c < 500; c++) begin
      adv();
      bus_gnt     = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'h9000 + 16'($urandom_range(0, 255));
        sb_q.delete(); push_walk(redirect_pc, 300);
      end else begin
        redirect_valid = 1'b0;
      end
      smp();
      vectors++;
      if (we !== 1'b0 || cs !== oe) begin
        miscompares++;
        $display("FAIL rand_bus: got we %b cs %b oe %b, required we 0 cs==oe", we, cs, oe);
      end
    end
    vectors++;
    if (accepted == 0) begin
      miscompares++;
      $display("FAIL rand_progress: got %0d instructions accepted, required > 0", accepted);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the CPU: walks the program counter over the 8-bit memory bus, reads opcode and operand bytes from the firmware ROM (mapped at 0x8000), assembles each 1- to 3-byte instruction, and hands it to decode over a valid/ready handshake. It is the bus master directly upstream of the ROM and the producer for the decode stage. It honours a bus grant from the arbiter and a PC redirect from execute.

## Interface
- RESET_VECTOR, 16'h8000, PC loaded on reset (ROM base).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  out  16  bus address; always equals fetch PC.
- cs  out  1  bus chip select.
- oe  out  1  bus output enable.
- we  out  1  bus write enable; constant 0.
- data_in  in  8  bus read data, valid combinationally in the same cycle as cs&oe.
- bus_gnt  in  1  arbiter grant; fetch may drive cs/oe only while high.
- redirect_valid  in  1  execute requests a PC change (jump/branch).
- redirect_pc  in  16  new fetch PC.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  decode accepts instruction.
- instr_opcode  out  8  opcode byte.
- instr_operand  out  16  operand; unused bytes 0.
- instr_len  out  2  length in bytes (1..3).
- instr_pc  out  16  address of the opcode byte.

## Operation
- States: OPC (fetch opcode), OP1 (fetch operand byte 1), OP2 (fetch operand byte 2), HOLD (instruction waiting for decode).
- Bus drive: cs = oe = !rst & bus_gnt & !redirect_valid & (state != HOLD); we = 0; addr = pc.
- A byte is consumed on a rising edge iff cs&oe were high in that cycle; then pc <= pc+1 (16-bit wrap, 0xFFFF -> 0x0000).
- Length from opcode: opcode[5:4] = 0 -> 1 byte; 1 -> 2 bytes; 2 or 3 -> 3 bytes.
- OPC consume: latch opcode, instr_pc <= pc, clear operand; len 1 -> HOLD, else -> OP1.
- OP1 consume: operand[7:0] <= data_in; len 2 -> HOLD, else -> OP2.
- OP2 consume: operand[15:8] <= data_in (little-endian); -> HOLD.
- HOLD: instr_valid = 1; outputs stable until accepted; on instr_valid&instr_ready -> OPC.
- No consume (bus_gnt low): state and pc hold; partial instruction retained.
- Redirect (priority over all but rst): pc <= redirect_pc, state <= OPC, partial or held instruction discarded, no bus access that cycle, no handshake completes that cycle even if instr_ready high.

## Timing
- Reset values: pc = RESET_VECTOR, state OPC, instr_valid 0, instr_opcode 0, instr_operand 0, instr_len 0, instr_pc 0; cs/oe 0 during rst cycle, we 0 always.
- With bus_gnt=1 and instr_ready=1: an N-byte instruction asserts instr_valid N cycles after its opcode cycle; throughput one instruction per N+1 cycles.
- First opcode read occurs in the first cycle after rst deasserts.
- instr_valid falls the cycle after acceptance; next opcode fetch is in that same cycle.
- Redirect in cycle T: first opcode read at redirect_pc in cycle T+1 (given grant).

## Structure
- Shared package cpu_pkg: RESET_VECTOR constant, fetch state enum, bus width constants (ADDR_W=16, DATA_W=8).
- One sub-module: opcode_len_dec (combinational opcode -> 2-bit length), reused later by decode.

## Test plan
- Reset, ROM bytes 02 07 04: first bus cycle addr=0x8000; first instr opcode 0x02, len 1, pc 0x8000, valid 1 cycle after opcode read.
- Bytes 11 34 12 at 0x8004: opcode 0x11, len 2, operand 0x0034; then 0x34's... (next opcode at 0x8006); bytes 30 80 07: len 3, operand 0x0780.
- instr_ready low for 5 cycles while valid: outputs constant, cs=0, pc unchanged; ready high -> next opcode fetched following cycle.
- bus_gnt low for 3 cycles between operand bytes of a 3-byte instr: no cs, operand assembled correctly after grant returns, latency +3.
- redirect_valid with redirect_pc=0x8010 while in OP1: partial discarded, next addr 0x8010, no spurious instr_valid.
- pc=0xFFFF fetching 1-byte opcode: next addr 0x0000; rst asserted in HOLD -> instr_valid 0, addr 0x8000 next cycle.
